mem_port_arbiter: RTL and testbench

- Shares the single-port synchronous RAM between two requesters:
  - port 0: the CPU memory path (MAR/MDR side of the control unit);
  - port 1: the I/O loader/DMA port.
- Runs one complete transaction (read or write) at a time through a small FSM.
- Ties go to round-robin arbitration.
- Sits between the requesters and the RAM, so the CPU's memory steps can stall on a grant instead of assuming exclusive RAM access.

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the CPU
// memory path (port 0) and the I/O loader/DMA port (port 1). One complete
// read or write runs at a time through IDLE -> ACCESS -> WAIT -> DONE.
// When both ports request in IDLE, round-robin picks the winner.
// Optional macro ARB_FIXED_PRIO_EN: port 0 always wins a tie. last_grant is
// still updated in that build but does not affect the choice.
module mem_port_arbiter #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_write,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WAIT   = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          any_req;
  logic          winner;
  logic          owner;
  logic          last_grant;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  // Choose which port wins the RAM if a request is sampled in IDLE
  always_comb begin
    any_req = req0 | req1;
`ifdef ARB_FIXED_PRIO_EN
    winner = ~req0;
`else
    if (req0 && req1) begin
      winner = ~last_grant;
    end else begin
      winner = ~req0;
    end
`endif
  end

  // State register; a reset drops any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: requests are only looked at in IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = WAIT;
      WAIT:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winner's request, record ownership and capture read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner      <= winner;
        last_grant <= winner;
        lat_we     <= winner ? we1 : we0;
        lat_addr   <= winner ? addr1 : addr0;
        lat_wdata  <= winner ? wdata1 : wdata0;
      end
      if (state == WAIT && !lat_we) begin
        if (owner) begin
          rdata1 <= ram_rdata;
        end else begin
          rdata0 <= ram_rdata;
        end
      end
    end
  end

  // Outputs decoded purely from registered state, never from the requests
  always_comb begin
    busy      = (state != IDLE);
    gnt0      = busy & ~owner;
    gnt1      = busy & owner;
    done0     = (state == DONE) & ~owner;
    done1     = (state == DONE) & owner;
    ram_write = (state == ACCESS) & lat_we;
    ram_addr  = lat_addr;
    ram_wdata = lat_wdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed stimulus for mem_port_arbiter,
// with a behavioural RAM, a transaction-order reference model and a
// scoreboard monitor that checks every done strobe.
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, done0, done1, busy, ram_write;
  logic [DW-1:0] rdata0, rdata1, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  typedef struct {
    bit            port;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t          sb[$];
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] last_rd [2];
  bit            model_last;
  int            checks = 0;
  int            failures = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_write(ram_write),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with one cycle of read latency
  always @(posedge clk) begin
    if (ram_write) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: transactions are served in the order they are pushed
  task automatic pushTxn(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    if (we) ref_mem[a] = d;
    else last_rd[p] = ref_mem[a];
    t.port  = p;
    t.rdata = last_rd[p];
    sb.push_back(t);
    model_last = p;
  endtask

  function automatic bit tieWinner();
`ifdef ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return ~model_last;
`endif
  endfunction

  task automatic setPort(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  // Scoreboard monitor: every done strobe pops and checks one expectation
  always @(negedge clk) begin
    txn_t t;
    if (rst_n) begin
      checkOutput("gnt_overlap", 32'(gnt0 & gnt1), 32'd0);
      if (done0 || done1) begin
        checkOutput("done_overlap", 32'(done0 & done1), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done: got done0=%b done1=%b expected none", done0, done1);
        end else begin
          t = sb.pop_front();
          checkOutput("done_port", 32'(done1), 32'(t.port));
          checkOutput("rdata", t.port ? rdata1 : rdata0, t.rdata);
        end
      end
    end
  end

  task automatic doReset();
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    checkOutput("rst_done", 32'({done1, done0}), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ram_write", 32'(ram_write), 32'd0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("rst_ram_wdata", ram_wdata, 32'd0);
    checkOutput("rst_rdata0", rdata0, 32'd0);
    checkOutput("rst_rdata1", rdata1, 32'd0);
    sb.delete();
    model_last = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    rst_n = 1'b1;
  endtask

  // One lone request with cycle-exact latency checks; call at a negedge in IDLE
  task automatic runSingle(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    setPort(p, we, a, d);
    pushTxn(p, we, a, d);
    @(negedge clk);
    checkOutput("k1_gnt", 32'(p ? gnt1 : gnt0), 32'd1);
    checkOutput("k1_gnt_other", 32'(p ? gnt0 : gnt1), 32'd0);
    checkOutput("k1_ram_write", 32'(ram_write), 32'(we));
    checkOutput("k1_ram_addr", 32'(ram_addr), 32'(a));
    if (we) checkOutput("k1_ram_wdata", ram_wdata, d);
    if (p) begin req1 = 1'b0; addr1 = 9'($urandom); wdata1 = $urandom; end
    else   begin req0 = 1'b0; addr0 = 9'($urandom); wdata0 = $urandom; end
    @(negedge clk);
    checkOutput("k2_gnt", 32'(p ? gnt1 : gnt0), 32'd1);
    checkOutput("k2_ram_write", 32'(ram_write), 32'd0);
    @(negedge clk);
    checkOutput("k3_gnt", 32'(p ? gnt1 : gnt0), 32'd1);
    checkOutput("k3_done", 32'(p ? done1 : done0), 32'd1);
    @(negedge clk);
    checkOutput("k4_busy", 32'(busy), 32'd0);
    checkOutput("k4_gnt", 32'({gnt1, gnt0}), 32'd0);
  endtask

  // Both ports hold read requests continuously for n transactions
  task automatic tieRun(input int n, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    int cnt = 0;
    int last_t = 0;
    setPort(1'b0, 1'b0, a0, '0);
    setPort(1'b1, 1'b0, a1, '0);
    for (int i = 0; i < n; i++) begin
      bit w = tieWinner();
      pushTxn(w, 1'b0, w ? a1 : a0, '0);
    end
    for (int c = 1; c <= n * 4 + 8; c++) begin
      @(negedge clk);
      if (done0 || done1) begin
        if (cnt > 0) checkOutput("tie_spacing", 32'(c - last_t), 32'd4);
        last_t = c;
        cnt++;
        if (cnt == n) begin
          req0 = 1'b0;
          req1 = 1'b0;
          break;
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("tie_count", 32'(cnt), 32'(n));
    @(negedge clk);
  endtask

  // Random rounds: one or both ports request, each holds until granted
  task automatic applyStimulus(input int rounds);
    for (int r = 0; r < rounds; r++) begin
      int  mask = $urandom_range(1, 3);
      bit  we_r [2];
      logic [AW-1:0] a_r [2];
      logic [DW-1:0] d_r [2];
      bool_done: begin
        for (int p = 0; p < 2; p++) begin
          we_r[p] = 1'($urandom);
          a_r[p]  = 9'($urandom_range(0, 16));
          d_r[p]  = $urandom;
          if (mask[p]) setPort(1'(p), we_r[p], a_r[p], d_r[p]);
        end
        if (mask == 3) begin
          bit w = tieWinner();
          pushTxn(w, we_r[w], a_r[w], d_r[w]);
          pushTxn(~w, we_r[~w], a_r[~w], d_r[~w]);
        end else begin
          bit p1 = (mask == 2);
          pushTxn(p1, we_r[p1], a_r[p1], d_r[p1]);
        end
      end
      begin
        bit ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (gnt0) req0 = 1'b0;
          if (gnt1) req1 = 1'b0;
          if (!req0 && !req1 && !busy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
          checks++;
          failures++;
          $display("[TB] FAIL round_timeout: got busy=%b req0=%b req1=%b expected idle", busy, req0, req1);
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
  endtask

  initial begin
    model_last = 1'b1;
    @(negedge clk);
    doReset();

    $display("[TB] filling RAM through the DMA port");
    for (int a = 0; a < 16; a++) runSingle(1'b1, 1'b1, 9'(a), $urandom);

    $display("[TB] directed CPU read and DMA write");
    runSingle(1'b1, 1'b1, 9'h010, 32'hDEADBEEF);
    runSingle(1'b0, 1'b0, 9'h010, '0);
    checkOutput("cpu_read_deadbeef", rdata0, 32'hDEADBEEF);
    runSingle(1'b1, 1'b1, 9'h1FF, 32'h12345678);
    runSingle(1'b0, 1'b0, 9'h1FF, '0);
    checkOutput("cpu_read_1ff", rdata0, 32'h12345678);
    runSingle(1'b1, 1'b0, 9'h1FF, '0);
    runSingle(1'b0, 1'b1, 9'h003, 32'hA5A5A5A5);
    checkOutput("write_keeps_rdata0", rdata0, 32'h12345678);

    $display("[TB] tie arbitration after reset");
    doReset();
    @(negedge clk);
    tieRun(4, 9'h003, 9'h005);

    $display("[TB] reset during a write ACCESS cycle");
    setPort(1'b1, 1'b1, 9'h007, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("midop_ram_write_before", 32'(ram_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midop_ram_write", 32'(ram_write), 32'd0);
    checkOutput("midop_gnt", 32'({gnt1, gnt0}), 32'd0);
    checkOutput("midop_busy", 32'(busy), 32'd0);
    req1 = 1'b0;
    @(negedge clk);
    doReset();
    @(negedge clk);
    tieRun(2, 9'h007, 9'h004);
    runSingle(1'b1, 1'b0, 9'h007, '0);

    $display("[TB] randomized rounds");
    applyStimulus(80);

    repeat (6) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
